serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 Port: clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: subtractor_input1  input  WIDTH  minuend; latched on the accepting edge.
REQ-006 Port: subtractor_input2  input  WIDTH  subtrahend; latched on the accepting edge.
REQ-007 Port: busy  output  1  high while in state BUSY.
REQ-008 Port: result_valid  output  1  high while in state DONE; result and flags are stable.
REQ-009 Port: result_ready  input  1  consumer acknowledge; sampled only in DONE.
REQ-010 Port: subtractor_output  output  WIDTH  difference, input1 - input2, modulo 2^WIDTH.
REQ-011 Port: borrow_out  output  1  unsigned borrow; 1 iff input1 < input2 as unsigned values.
REQ-012 Port: zero_flag  output  1  1 iff subtractor_output == 0.
REQ-013 Port: overflow_flag  output  1  two's-complement overflow of the signed subtraction.

Function
REQ-014 The block SHALL implement the FSM states IDLE, BUSY and DONE, with IDLE as the reset state.
REQ-015 IDLE->BUSY: start=1 at a rising edge; on that same edge, latch both operands, clear the bit counter, and clear the internal borrow.
REQ-016 In BUSY, each edge SHALL process one bit, LSB first:
- diff = a ^ b ^ br
- br_next = (~a & b) | (~a & br) | (b & br)
- diff is shifted into the result register from the MSB side.
REQ-017 BUSY->DONE: on the WIDTH-th BUSY edge, result_valid rises exactly WIDTH edges after the accepting edge (8 for WIDTH=8).
REQ-018 On entry to DONE, the block SHALL register the flags:
- borrow_out = final borrow
- zero_flag = (result == 0)
- overflow_flag = (a_msb != b_msb) & (result_msb != a_msb)
REQ-019 DONE->IDLE: result_ready=1 at a rising edge; the next start is accepted no earlier than the following edge.
REQ-020 subtractor_output and all flags SHALL hold their last values in IDLE and BUSY until overwritten on the next entry to DONE; they may show partial values during BUSY and are valid only while result_valid=1.
REQ-021 start asserted in BUSY or DONE SHALL be ignored, not queued; changes on the operand inputs after acceptance SHALL NOT affect the result.
REQ-022 start and result_ready both high in DONE: the result SHALL be consumed, the block SHALL go to IDLE, and start SHALL be ignored.
REQ-023 result_ready SHALL be ignored in IDLE and BUSY.
REQ-024 result_valid SHALL remain high indefinitely while result_ready stays low (backpressure).
REQ-025 busy and result_valid SHALL never be high simultaneously.

Reset
REQ-026 While rst_n=0 the block SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-027 While rst_n=0, busy, result_valid, subtractor_output, borrow_out, zero_flag and overflow_flag SHALL all be 0, and the bit counter and internal borrow SHALL be cleared.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result delivered; the first start after rst_n deasserts SHALL be handled normally.

Verification
REQ-029 input1=5, input2=3, start pulse -> after 8 edges result_valid=1, output=2, borrow=0, zero=0, overflow=0.
REQ-030 input1=3, input2=5 -> output=254 (0xFE), borrow=1, zero=0, overflow=0; 5-5 -> output=0, zero=1, borrow=0.
REQ-031 input1=128, input2=1 -> output=127, overflow=1, borrow=0; input1=127, input2=255 -> output=128, overflow=1, borrow=1.
REQ-032 Hold result_ready=0 for 20 cycles after DONE -> result_valid and output stay stable; pulse result_ready -> IDLE next edge, result_valid=0.
REQ-033 start held high continuously with operands changing during BUSY -> exactly one result, computed from operands latched at the accepting edge; a new operation begins only after the DONE->IDLE handshake.
REQ-034 rst_n pulled low after 4 BUSY edges -> all outputs 0 immediately; after release, 10-4 -> output=6 with normal 8-edge latency.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first, one bit per clock) with IDLE/BUSY/DONE handshake.
// Latency: WIDTH edges from accept to result_valid; result held until result_ready.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] subtractor_input1,
  input  logic [WIDTH-1:0] subtractor_input2,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] subtractor_output,
  output logic             borrow_out,
  output logic             zero_flag,
  output logic             overflow_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             a_bit, b_bit, diff_bit, br_nxt;
  logic [WIDTH-1:0] res_shift;

  // Operands stay unshifted so their MSBs remain available for the overflow flag.
  always_comb begin
    a_bit     = a_q[cnt_q];
    b_bit     = b_q[cnt_q];
    diff_bit  = a_bit ^ b_bit ^ br_q;
    br_nxt    = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
    res_shift = {diff_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = subtractor_input1;
          b_d     = subtractor_input2;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d = res_shift;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          borrow_d = br_nxt;
          zero_d   = (res_shift == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_bit != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy              = (state_q == BUSY);
  assign result_valid      = (state_q == DONE);
  assign subtractor_output = res_q;
  assign borrow_out        = borrow_q;
  assign zero_flag         = zero_q;
  assign overflow_flag     = ovf_q;

endmodule
